// File: rtl/heq_lut_scheduler_pkg.sv
// Shared definitions for the histogram-equalisation LUT builder:
// FSM state encoding, default sizing and the LUT saturation value.
package heq_lut_scheduler_pkg;

   localparam int unsigned BINS_DEF = 256;
   localparam int unsigned SIZE_DEF = 1600;
   localparam int unsigned TMO_DEF  = 128;
   localparam int unsigned LPOW     = 8;
   localparam int unsigned LUT_MAX  = (1 << LPOW) - 1;

   typedef enum logic [3:0] {
      IDLE,
      SCAN_RD,
      SCAN_CHK,
      LOAD_RD,
      LOAD_SET,
      DIV_GO,
      DIV_WAIT,
      WRITE,
      FIN
   } state_t;

   function automatic logic [LPOW-1:0] sat_lut(input logic [31:0] g);
      return (g > 32'(LUT_MAX)) ? LPOW'(LUT_MAX) : g[LPOW-1:0];
   endfunction

endpackage

// File: rtl/heq_lut_scheduler.sv
// Builds the equalisation LUT: scans the CDF RAM for the first nonzero bin,
// then sends every bin through the external divider and writes the result.
module heq_lut_scheduler
   import heq_lut_scheduler_pkg::*;
#(
   parameter int unsigned BINS = BINS_DEF,
   parameter int unsigned SIZE = SIZE_DEF,
   parameter int unsigned TMO  = TMO_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cdf_rd_en,
   output logic [7:0]  cdf_addr,
   input  logic [31:0] cdf_rd_data,
   output logic [31:0] cdf_min,
   output logic [31:0] cdf_in,
   output logic        div_en,
   input  logic [31:0] g_out,
   input  logic        ready_g_out,
   output logic        lut_wr_en,
   output logic [7:0]  lut_addr,
   output logic [7:0]  lut_wr_data
);

   localparam int unsigned TW = $clog2(TMO) + 1;

   state_t          state, state_nxt;
   logic [7:0]      addr;
   logic [31:0]     cdf_in_q;
   logic [7:0]      wdata;
   logic [TW-1:0]   tmo_cnt;
   logic            last;
   logic            rd_zero;
   logic            div_skip;
   logic            tmo_hit;

   assign last     = (addr == 8'(BINS - 1));
   assign rd_zero  = (cdf_rd_data == '0);
   assign div_skip = rd_zero || (cdf_min == 32'(SIZE));
   assign tmo_hit  = (tmo_cnt == TW'(TMO - 1));

   assign busy        = (state != IDLE);
   assign cdf_addr    = addr;
   // Read data is forwarded during LOAD_SET so the operand is already
   // stable one cycle before div_en, as the divider's input stage expects.
   assign cdf_in      = (state == LOAD_SET) ? cdf_rd_data : cdf_in_q;
   assign lut_addr    = (state == WRITE) ? addr : '0;
   assign lut_wr_data = (state == WRITE) ? wdata : '0;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cdf_rd_en = 1'b0;
      div_en    = 1'b0;
      done      = 1'b0;
      lut_wr_en = 1'b0;
      unique case (state)
         IDLE:     if (start) state_nxt = SCAN_RD;
         SCAN_RD: begin
            cdf_rd_en = 1'b1;
            state_nxt = SCAN_CHK;
         end
         SCAN_CHK: state_nxt = (!rd_zero || last) ? LOAD_RD : SCAN_RD;
         LOAD_RD: begin
            cdf_rd_en = 1'b1;
            state_nxt = LOAD_SET;
         end
         LOAD_SET: state_nxt = div_skip ? WRITE : DIV_GO;
         DIV_GO: begin
            div_en    = 1'b1;
            state_nxt = DIV_WAIT;
         end
         DIV_WAIT: begin
            if (ready_g_out)  state_nxt = WRITE;
            else if (tmo_hit) state_nxt = IDLE;
         end
         WRITE: begin
            lut_wr_en = !reset;
            state_nxt = last ? FIN : LOAD_RD;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr     <= '0;
         cdf_min  <= '0;
         cdf_in_q <= '0;
         wdata    <= '0;
         tmo_cnt  <= '0;
         error    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               error    <= 1'b0;
               addr     <= '0;
               cdf_min  <= '0;
               cdf_in_q <= '0;
            end
            SCAN_CHK: begin
               if (!rd_zero) begin
                  cdf_min <= cdf_rd_data;
                  addr    <= '0;
               end else if (last) begin
                  addr <= '0;
               end else begin
                  addr <= addr + 8'd1;
               end
            end
            LOAD_SET: begin
               cdf_in_q <= cdf_rd_data;
               tmo_cnt  <= '0;
               if (rd_zero)       wdata <= '0;
               else if (div_skip) wdata <= 8'(LUT_MAX);
            end
            DIV_WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (ready_g_out) begin
                  wdata <= sat_lut(g_out);
               end else if (tmo_hit) begin
                  error    <= 1'b1;
                  cdf_in_q <= '0;
               end
            end
            WRITE: if (!last) addr <= addr + 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_heq_lut_scheduler.sv
// Scoreboard bench for heq_lut_scheduler with CDF RAM and divider models.
module tb_heq_lut_scheduler;

   localparam int unsigned BINS = 256;
   localparam int unsigned SIZE = 1600;
   localparam int unsigned TMO  = 128;

   logic        clk = 1'b0;
   logic        reset, start;
   logic        busy, done, error, cdf_rd_en, div_en, ready_g_out, lut_wr_en;
   logic [7:0]  cdf_addr, lut_addr, lut_wr_data;
   logic [31:0] cdf_rd_data, cdf_min, cdf_in, g_out;

   heq_lut_scheduler #(.BINS(BINS), .SIZE(SIZE), .TMO(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .error(error), .cdf_rd_en(cdf_rd_en), .cdf_addr(cdf_addr),
      .cdf_rd_data(cdf_rd_data), .cdf_min(cdf_min), .cdf_in(cdf_in),
      .div_en(div_en), .g_out(g_out), .ready_g_out(ready_g_out),
      .lut_wr_en(lut_wr_en), .lut_addr(lut_addr), .lut_wr_data(lut_wr_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   logic [31:0] mem [BINS];
   wr_t         exp_q[$];
   int          n_chk = 0, n_pass = 0;
   int          div_cnt = 0, done_cnt = 0;
   bit          stall = 1'b0, ovr_on = 1'b0;
   logic [31:0] ovr_cdf = '0, exp_min = '0;
   int          pend_cnt = 0;
   logic [31:0] pend_val = '0;

   function automatic void check(string name, longint unsigned act, longint unsigned exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endfunction

   // Ideal equalisation: round((cdf - min) * (L-1) / (SIZE - min)).
   function automatic logic [31:0] heq(logic [31:0] c, logic [31:0] m);
      longint unsigned num, den;
      den = longint'(SIZE) - longint'(m);
      if (den == 0 || c < m) return '0;
      num = longint'(c - m) * 255;
      return 32'((num + den / 2) / den);
   endfunction

   // CDF RAM: one-cycle read latency, junk on the bus when not reading.
   always @(posedge clk) cdf_rd_data <= cdf_rd_en ? mem[cdf_addr] : $urandom();

   // Divider: random latency, optional override value, optional stall,
   // and stray ready pulses while no division is outstanding.
   always @(posedge clk) begin
      ready_g_out <= 1'b0;
      g_out       <= 32'd77;
      if (reset) begin
         pend_cnt <= 0;
      end else if (div_en) begin
         if (!stall) begin
            pend_cnt <= int'($urandom_range(1, 4));
            pend_val <= (ovr_on && cdf_in == ovr_cdf) ? 32'd300 : heq(cdf_in, cdf_min);
         end
      end else if (pend_cnt == 1) begin
         ready_g_out <= 1'b1;
         g_out       <= pend_val;
         pend_cnt    <= 0;
      end else if (pend_cnt > 1) begin
         pend_cnt <= pend_cnt - 1;
      end else if (!stall && $urandom_range(0, 7) == 0) begin
         ready_g_out <= 1'b1;
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (div_en) div_cnt++;
      if (done) done_cnt++;
      if (lut_wr_en) begin
         if (exp_q.size() == 0) begin
            check("write_pending", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("lut_addr", lut_addr, e.a);
            check("lut_wr_data", lut_wr_data, e.d);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (busy && n < 8000) begin
         cyc();
         n++;
      end
      check({name, "_idle"}, busy, 0);
   endtask

   task automatic check_reset_vals(string name);
      check({name, "_busy"}, busy, 0);
      check({name, "_done"}, done, 0);
      check({name, "_error"}, error, 0);
      check({name, "_cdf_rd_en"}, cdf_rd_en, 0);
      check({name, "_div_en"}, div_en, 0);
      check({name, "_lut_wr_en"}, lut_wr_en, 0);
      check({name, "_cdf_addr"}, cdf_addr, 0);
      check({name, "_lut_addr"}, lut_addr, 0);
      check({name, "_lut_wr_data"}, lut_wr_data, 0);
      check({name, "_cdf_min"}, cdf_min, 0);
      check({name, "_cdf_in"}, cdf_in, 0);
   endtask

   // Queue the expected writes for bins 0..nb-1 from the current CDF.
   task automatic load_expect(int nb);
      logic [31:0] g;
      wr_t         w;
      exp_min = '0;
      for (int k = BINS - 1; k >= 0; k--) if (mem[k] != 0) exp_min = mem[k];
      for (int k = 0; k < nb; k++) begin
         if (mem[k] == 0)                          g = '0;
         else if (exp_min == SIZE)                 g = 32'd255;
         else if (ovr_on && mem[k] == ovr_cdf)     g = 32'd300;
         else                                      g = heq(mem[k], exp_min);
         w.a = 8'(k);
         w.d = (g > 255) ? 8'd255 : g[7:0];
         exp_q.push_back(w);
      end
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < BINS; k++)
         mem[k] = (k < 10) ? 32'd0 : 32'(10 + ((k - 10) * 1590) / 245);
   endtask

   task automatic build(string name, bit mid_start);
      int d0 = done_cnt;
      load_expect(BINS);
      pulse_start();
      if (mid_start) begin
         repeat (400) cyc();
         pulse_start();
      end
      wait_idle(name);
      repeat (2) cyc();
      check({name, "_done_pulses"}, done_cnt - d0, 1);
      check({name, "_cdf_min"}, cdf_min, exp_min);
      check({name, "_queue_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int n, d0, v0;
      reset = 1'b1;
      start = 1'b0;
      for (int k = 0; k < BINS; k++) mem[k] = '0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_vals("por");
      reset = 1'b0;
      cyc();

      // Ramp with one over-range divider result and a start while busy.
      fill_ramp();
      ovr_on  = 1'b1;
      ovr_cdf = mem[50];
      build("ramp", 1'b1);
      check("ramp_min10", cdf_min, 10);
      ovr_on = 1'b0;

      // Every bin at SIZE: divisor zero, divider must never be used.
      for (int k = 0; k < BINS; k++) mem[k] = SIZE;
      v0 = div_cnt;
      build("full", 1'b0);
      check("full_no_div_en", div_cnt - v0, 0);

      // Empty histogram.
      for (int k = 0; k < BINS; k++) mem[k] = '0;
      build("empty", 1'b0);

      // Random monotone CDF.
      begin
         int unsigned zb = $urandom_range(0, 40);
         logic [31:0] acc = '0;
         for (int k = 0; k < BINS; k++) begin
            if (k >= int'(zb)) acc = acc + $urandom_range(0, 12);
            if (acc > SIZE) acc = SIZE;
            mem[k] = acc;
         end
      end
      build("rand", 1'b0);

      // Divider never answers: timeout after TMO cycles in DIV_WAIT.
      fill_ramp();
      stall = 1'b1;
      d0 = done_cnt;
      load_expect(10);
      pulse_start();
      n = 0;
      while (!div_en && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("tmo_div_en_seen", div_en, 1);
      n = 0;
      while (!error && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles", n, TMO + 1);
      check("tmo_error", error, 1);
      check("tmo_busy", busy, 0);
      check("tmo_div_en", div_en, 0);
      check("tmo_cdf_in", cdf_in, 0);
      repeat (3) cyc();
      check("tmo_no_done", done_cnt - d0, 0);
      check("tmo_queue_left", exp_q.size(), 0);

      // Restart clears the sticky error and rebuilds normally.
      stall = 1'b0;
      load_expect(BINS);
      d0 = done_cnt;
      pulse_start();
      check("restart_error_clear", error, 0);
      wait_idle("restart");
      repeat (2) cyc();
      check("restart_done", done_cnt - d0, 1);
      check("restart_queue_left", exp_q.size(), 0);

      // Reset while waiting on the divider for bin 100.
      load_expect(100);
      d0 = done_cnt;
      pulse_start();
      n = 0;
      while (!(div_en && cdf_addr == 8'd100) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("rst_reached_bin100", cdf_addr, 100);
      cyc();
      reset = 1'b1;
      @(posedge clk);
      #2;
      check_reset_vals("midrst");
      reset = 1'b0;
      cyc();
      check("midrst_queue_left", exp_q.size(), 0);
      check("midrst_no_done", done_cnt - d0, 0);
      build("rebuild", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/heq_lut_scheduler.md
HEQ_LUT_SCHEDULER -- requirements
Module: heq_lut_scheduler

Interface
REQ-001 SHALL have parameter BINS, default 256, number of histogram bins / LUT entries.
REQ-002 SHALL have parameter SIZE, default 1600, pixel count per frame (must equal the divider's SIZE).
REQ-003 SHALL have parameter TMO, default 128, max cycles to wait for ready_g_out.
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-005 SHALL have ports: start in 1 begin LUT build; busy out 1; done out 1 one-cycle completion pulse; error out 1 sticky timeout flag, cleared by start.
REQ-006 SHALL have ports: cdf_rd_en out 1; cdf_addr out 8; cdf_rd_data in 32, CDF RAM, read data valid exactly 1 cycle after cdf_rd_en.
REQ-007 SHALL have ports: cdf_min out 32; cdf_in out 32; div_en out 1; g_out in 32; ready_g_out in 1, all connected to divider.
REQ-008 SHALL have ports: lut_wr_en out 1; lut_addr out 8; lut_wr_data out 8, LUT RAM write port.

Function
REQ-009 SHALL implement FSM states IDLE, SCAN_RD, SCAN_CHK, LOAD_RD, LOAD_SET, DIV_GO, DIV_WAIT, WRITE, FIN.
REQ-010 SHALL leave IDLE for SCAN_RD on start=1; start while busy=1 SHALL be ignored; busy=1 in every state except IDLE.
REQ-011 Scan phase SHALL read bins 0..BINS-1 in order (SCAN_RD issues read, SCAN_CHK checks data); first nonzero value SHALL latch into cdf_min and end the scan.
REQ-012 If all bins are zero, cdf_min SHALL be 0 and the LUT phase SHALL write 0 to every entry.
REQ-013 LUT phase SHALL process bins 0..BINS-1 in order: LOAD_RD reads bin k, LOAD_SET drives cdf_in = data and holds it stable through WRITE.
REQ-014 If cdf_in = 0, controller SHALL skip the divider and write 0 for bin k.
REQ-015 If cdf_min = SIZE (divisor zero), controller SHALL skip the divider and write 255 for every nonzero bin.
REQ-016 Otherwise DIV_GO SHALL assert div_en for exactly one cycle, one cycle after cdf_in becomes stable (the divider's operand-register stage), then enter DIV_WAIT.
REQ-017 DIV_WAIT SHALL capture g_out on the first cycle ready_g_out=1 and go to WRITE; ready_g_out outside DIV_WAIT SHALL be ignored.
REQ-018 WRITE SHALL assert lut_wr_en for one cycle with lut_addr = k, lut_wr_data = min(g_out, 255).
REQ-019 If DIV_WAIT lasts TMO cycles without ready_g_out, controller SHALL set error, drop div_en/cdf_in to 0, and return to IDLE without done.
REQ-020 After bin BINS-1 is written, FIN SHALL pulse done for one cycle and return to IDLE; cdf_min SHALL hold its value until the next start.
REQ-021 cdf_addr counter SHALL not wrap: address BINS-1 is the last access of each phase.

Reset
REQ-022 On reset, FSM SHALL enter IDLE next cycle, including mid-operation.
REQ-023 Reset values SHALL be: busy, done, error, cdf_rd_en, div_en, lut_wr_en = 0; cdf_addr, lut_addr, lut_wr_data = 0; cdf_min, cdf_in = 0.
REQ-024 No LUT write SHALL occur in the cycle reset is asserted.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, BINS/SIZE/TMO defaults and the 255 saturation constant (L-1, L = 2^LPOW with LPOW = 8).
REQ-026 Block SHALL contain no sub-module; the divider module stays external and is instantiated alongside in the top-level pipeline.

Verification
REQ-027 CDF = 0 for bins 0..9, 10 for bin 10 rising linearly to 1600 at bin 255; start -> cdf_min = 10; LUT[0..9] = 0; LUT[255] = 255.
REQ-028 All bins 1600 -> cdf_min = 1600; no div_en ever asserted; every LUT entry = 255; done pulses once.
REQ-029 All bins 0 -> cdf_min = 0; 256 writes of 0; done pulses once.
REQ-030 Divider model holds ready_g_out low -> error = 1 after 128 DIV_WAIT cycles; FSM returns to IDLE; no done.
REQ-031 Reset asserted during DIV_WAIT at bin 100 -> next cycle all outputs at reset values; new start rebuilds LUT correctly from bin 0.
REQ-032 Model returns g_out = 300 for one bin -> lut_wr_data = 255 for that bin; start pulsed while busy -> no effect.
